// File: rtl/rv32i_types.sv
// Shared RV32 types for the M-extension path: funct3 encodings and controller states.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv32i_types;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RECOVER = 2'd3
    } m_ctrl_state_t;

endpackage

// File: rtl/m_ext_replay_cache.sv
// One-entry replay cache keyed by {funct3, rs1, rs2}, holding the last unit result.
// Latency: hit is combinational on the lookup key; a write is visible the next cycle.
// Backpressure: none; the controller writes only when the unit hands back a result.
module m_ext_replay_cache
    import rv32i_types::*;
#(
    parameter int XLEN = 32,
    parameter bit EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_wr,
    input  logic [2:0]      i_wr_funct3,
    input  logic [XLEN-1:0] i_wr_rs1,
    input  logic [XLEN-1:0] i_wr_rs2,
    input  logic [XLEN-1:0] i_wr_result,
    input  logic [2:0]      i_lk_funct3,
    input  logic [XLEN-1:0] i_lk_rs1,
    input  logic [XLEN-1:0] i_lk_rs2,
    output logic            o_hit,
    output logic [XLEN-1:0] o_result
);

    logic            r_valid;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_result;

    // Capture the tag and result of each op the unit completes; reset invalidates the entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_funct3 <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_result <= '0;
        end else if (i_wr) begin
            r_valid  <= 1'b1;
            r_funct3 <= i_wr_funct3;
            r_rs1    <= i_wr_rs1;
            r_rs2    <= i_wr_rs2;
            r_result <= i_wr_result;
        end
    end

    assign o_hit    = EN && r_valid && (r_funct3 == i_lk_funct3)
                      && (r_rs1 == i_lk_rs1) && (r_rs2 == i_lk_rs2);
    assign o_result = r_result;

endmodule

// File: rtl/m_ext_ctrl.sv
// Sequencer between EX and the mul/div unit: latches operands, strobes the unit, replays repeats.
// Latency: miss done at cycle k -> result_valid_o the cycle after; cache hit -> result_valid_o next cycle.
// Backpressure: stall_o holds IF/ID/EX until DONE; the result is held until pipe_advance_i or flush_i.
module m_ext_ctrl
    import rv32i_types::*;
#(
    parameter int XLEN       = 32,
    parameter bit CACHE_EN   = 1'b1,
    parameter int MAX_CYCLES = 40
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    input  logic            pipe_advance_i,
    input  logic            alu_done_i,
    input  logic [XLEN-1:0] alu_result_i,
    output logic            alu_active_o,
    output logic [2:0]      alu_funct3_o,
    output logic [XLEN-1:0] alu_rs1_o,
    output logic [XLEN-1:0] alu_rs2_o,
    output logic            stall_o,
    output logic            result_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            err_o
);

    localparam int               CNT_W    = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    m_ctrl_state_t   r_state;
    m_ctrl_state_t   w_next;
    m_funct3_t       r_funct3;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic            r_err;
    logic            r_used;

    logic            w_accept;
    logic            w_hit;
    logic [XLEN-1:0] w_hit_result;
    logic            w_done_ok;
    logic            w_timeout;

    // Flush outranks both a finishing unit and the watchdog; the timeout fires on the
    // last allowed BUSY cycle so the unit is never active for more than MAX_CYCLES.
    assign w_accept  = (r_state == IDLE) && req_valid_i && !flush_i;
    assign w_done_ok = (r_state == BUSY) && !flush_i && alu_done_i;
    assign w_timeout = (r_state == BUSY) && !flush_i && !alu_done_i && (r_cnt == CNT_LAST);

    m_ext_replay_cache #(
        .XLEN (XLEN),
        .EN   (CACHE_EN)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .i_wr        (w_done_ok),
        .i_wr_funct3 (r_funct3),
        .i_wr_rs1    (r_rs1),
        .i_wr_rs2    (r_rs2),
        .i_wr_result (alu_result_i),
        .i_lk_funct3 (funct3_i),
        .i_lk_rs1    (rs1_i),
        .i_lk_rs2    (rs2_i),
        .o_hit       (w_hit),
        .o_result    (w_hit_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand latches, result register, unit-used flag and watchdog counter/flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_funct3 <= M_MUL;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_used   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct3 <= m_funct3_t'(funct3_i);
                r_rs1    <= rs1_i;
                r_rs2    <= rs2_i;
                r_cnt    <= '0;
                r_used   <= !w_hit;
                if (w_hit) begin
                    r_result <= w_hit_result;
                end
            end
            if (r_state == BUSY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done_ok) begin
                r_result <= alu_result_i;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Next state and state-decoded outputs; a hit never touched the unit so it skips RECOVER
    always_comb begin
        w_next         = r_state;
        alu_active_o   = 1'b0;
        result_valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_hit ? DONE : BUSY;
                end
            end
            BUSY: begin
                alu_active_o = 1'b1;
                if (flush_i || w_timeout) begin
                    w_next = RECOVER;
                end else if (alu_done_i) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                result_valid_o = 1'b1;
                if (flush_i || pipe_advance_i) begin
                    w_next = r_used ? RECOVER : IDLE;
                end
            end
            RECOVER: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign stall_o      = req_valid_i && !flush_i && (r_state != DONE);
    assign alu_funct3_o = r_funct3;
    assign alu_rs1_o    = r_rs1;
    assign alu_rs2_o    = r_rs2;
    assign result_o     = r_result;
    assign err_o        = r_err;

endmodule
